// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply and
// restoring divide, one bit per cycle, with a start/done handshake.
module muldiv_unit #(
    parameter int XLEN  = 32,
    parameter int CNT_W = $clog2(XLEN) + 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            flush,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] A,
    input  logic [XLEN-1:0] B,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_MULHU  = 3'b011;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_DIVU   = 3'b101;
    localparam logic [2:0] OP_REM    = 3'b110;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [2:0]        op_q, op_d;
    logic [2*XLEN-1:0] prod_q, prod_d;
    logic [XLEN-1:0]   rem_q, rem_d;
    logic [XLEN-1:0]   dvs_q, dvs_d;
    logic              neg_q, neg_d;
    logic              rneg_q, rneg_d;
    logic              dz_q, dz_d;
    logic              done_q, done_d;
    logic [XLEN-1:0]   result_q, result_d;

    logic              accept;
    logic              sgn_a, sgn_b, a_neg, b_neg;
    logic [XLEN-1:0]   a_mag, b_mag;
    logic [XLEN:0]     mul_sum, r_shift, r_diff;
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quo, quo_fix, rem_fix;

    assign accept = (state_q == IDLE) && start && !flush;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; flush overrides everything
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = CALC;
            CALC:    if (cnt_q == CNT_W'(1)) state_d = FIX;
            FIX:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (flush) state_d = IDLE;
    end

    // Output logic
    always_comb begin
        busy   = (state_q != IDLE);
        done   = done_q;
        result = result_q;
    end

    always_comb begin
        sgn_a = (op == OP_MULH) || (op == OP_MULHSU) ||
                (op == OP_DIV)  || (op == OP_REM);
        sgn_b = (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
        a_neg = sgn_a & A[XLEN-1];
        b_neg = sgn_b & B[XLEN-1];
        a_mag = a_neg ? -A : A;
        b_mag = b_neg ? -B : B;
    end

    // Product lives in prod_q; for divide the low half shifts the
    // dividend out MSB-first while quotient bits shift in.
    always_comb begin
        quo      = prod_q[XLEN-1:0];
        mul_sum  = {1'b0, prod_q[2*XLEN-1:XLEN]} +
                   (prod_q[0] ? {1'b0, dvs_q} : '0);
        r_shift  = {rem_q, prod_q[XLEN-1]};
        r_diff   = r_shift - {1'b0, dvs_q};
        prod_fix = neg_q ? -prod_q : prod_q;
        quo_fix  = dz_q ? '1 : (neg_q ? -quo : quo);
        rem_fix  = rneg_q ? -rem_q : rem_q;
    end

    always_comb begin
        cnt_d    = cnt_q;
        op_d     = op_q;
        prod_d   = prod_q;
        rem_d    = rem_q;
        dvs_d    = dvs_q;
        neg_d    = neg_q;
        rneg_d   = rneg_q;
        dz_d     = dz_q;
        done_d   = 1'b0;
        result_d = result_q;
        if (accept) begin
            op_d   = op;
            prod_d = {{XLEN{1'b0}}, a_mag};
            rem_d  = '0;
            dvs_d  = b_mag;
            neg_d  = a_neg ^ b_neg;
            rneg_d = a_neg;
            dz_d   = (B == '0);
            cnt_d  = CNT_W'(XLEN);
        end else if (flush) begin
            cnt_d = '0;
        end else if (state_q == CALC) begin
            cnt_d = cnt_q - CNT_W'(1);
            if (!op_q[2]) begin
                prod_d = {mul_sum, prod_q[XLEN-1:1]};
            end else if (!r_diff[XLEN]) begin
                rem_d               = r_diff[XLEN-1:0];
                prod_d[XLEN-1:0]    = {quo[XLEN-2:0], 1'b1};
            end else begin
                rem_d               = r_shift[XLEN-1:0];
                prod_d[XLEN-1:0]    = {quo[XLEN-2:0], 1'b0};
            end
        end else if (state_q == FIX) begin
            done_d = 1'b1;
            case (op_q)
                OP_MUL:                      result_d = prod_fix[XLEN-1:0];
                OP_MULH, OP_MULHSU, OP_MULHU: result_d = prod_fix[2*XLEN-1:XLEN];
                OP_DIV, OP_DIVU:             result_d = quo_fix;
                default:                     result_d = rem_fix;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            op_q     <= '0;
            prod_q   <= '0;
            rem_q    <= '0;
            dvs_q    <= '0;
            neg_q    <= 1'b0;
            rneg_q   <= 1'b0;
            dz_q     <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
        end else begin
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            prod_q   <= prod_d;
            rem_q    <= rem_d;
            dvs_q    <= dvs_d;
            neg_q    <= neg_d;
            rneg_q   <= rneg_d;
            dz_q     <= dz_d;
            done_q   <= done_d;
            result_q <= result_d;
        end
    end

endmodule
